// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word memory answering core load/store requests after WAIT_CYCLES wait states
// Optional macro DMEM_ERR_CHECK_EN: flag out-of-range or misaligned addresses and suppress their effects.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   input  logic [3:0]  ByteEn,
   output logic        Ready,
   output logic [31:0] ReadData,
   output logic        Err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state;
   logic [3:0]    cnt;
   logic [AW-1:0] lat_idx;
   logic [31:0]   lat_data;
   logic [3:0]    lat_be;
   logic          lat_we;
   logic          lat_err;

   logic [31:0]   mem [DEPTH_WORDS];

   logic          req;
   logic          in_err;
   logic          go_resp;
   logic          commit;
   logic [AW-1:0] cur_idx;
   logic [31:0]   cur_data;
   logic [3:0]    cur_be;
   logic          cur_we;
   logic          cur_err;
   logic [31:0]   stored;
   logic [31:0]   merged;
   logic [31:0]   resp_data;

`ifdef DMEM_ERR_CHECK_EN
   assign in_err = (DataAdr >= 32'(4 * DEPTH_WORDS)) || (DataAdr[1:0] != 2'b00);
`else
   logic unused_addr_bits;
   assign unused_addr_bits = ^{DataAdr[31:AW+2], DataAdr[1:0]};
   assign in_err = 1'b0;
`endif

   assign req = MemWrite | MemRead;

   // With zero wait states the response is formed on the accepting edge, so use the live inputs.
   assign cur_idx  = (state == IDLE) ? DataAdr[AW+1:2] : lat_idx;
   assign cur_data = (state == IDLE) ? WriteData : lat_data;
   assign cur_be   = (state == IDLE) ? ByteEn : lat_be;
   assign cur_we   = (state == IDLE) ? MemWrite : lat_we;
   assign cur_err  = (state == IDLE) ? in_err : lat_err;

   assign go_resp = ((state == IDLE) && req && (WAIT_CYCLES == 0)) ||
                    ((state == WAIT) && (cnt == 4'd0));

   always_comb begin
      stored = mem[cur_idx];
      merged = stored;
      for (int i = 0; i < 4; i++) begin
         if (cur_be[i]) merged[8*i +: 8] = cur_data[8*i +: 8];
      end
      if (cur_err)     resp_data = 32'd0;
      else if (cur_we) resp_data = merged;
      else             resp_data = stored;
   end

   // Gated by reset so a request seen while reset is held can never reach memory.
   assign commit = go_resp && cur_we && !cur_err && reset;

   always_ff @(posedge clk) begin
      if (commit) mem[cur_idx] <= merged;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         Ready    <= 1'b0;
         Err      <= 1'b0;
         ReadData <= 32'd0;
         lat_idx  <= '0;
         lat_data <= 32'd0;
         lat_be   <= 4'd0;
         lat_we   <= 1'b0;
         lat_err  <= 1'b0;
      end else begin
         Ready <= go_resp;
         Err   <= go_resp & cur_err;
         if (go_resp) ReadData <= resp_data;
         case (state)
            IDLE: begin
               if (req) begin
                  lat_idx  <= DataAdr[AW+1:2];
                  lat_data <= WriteData;
                  lat_be   <= ByteEn;
                  lat_we   <= MemWrite;
                  lat_err  <= in_err;
                  if (WAIT_CYCLES > 0) begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end else begin
                     state <= RESP;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) state <= RESP;
               else             cnt   <= cnt - 4'd1;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
